// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the load/store unit and memory.
// master: LSU drives req/we/be/addr/wdata; slave: memory drives gnt/rvalid/rdata.
interface lsu_ctrl_if;
    logic        data_req;
    logic        data_gnt;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    modport master (
        output data_req,
        output data_we,
        output data_be,
        output data_addr,
        output data_wdata,
        input  data_gnt,
        input  data_rvalid,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_we,
        input  data_be,
        input  data_addr,
        input  data_wdata,
        output data_gnt,
        output data_rvalid,
        output data_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32 load/store controller, one outstanding access.
// Ports: clk/reset; ex_* op from decode; lsu_busy stall; lsu_misaligned
// fault pulse; bus (master side of data memory); wb_* register write port.
module lsu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_lsu_valid,
    input  logic        ex_lsu_wr_type,
    input  logic [2:0]  ex_lsu_width_type,
    input  logic [31:0] ex_lsu_addr,
    input  logic [31:0] ex_lsu_wdata,
    input  logic [4:0]  ex_dest_addr,
    output logic        lsu_busy,
    output logic        lsu_misaligned,
    lsu_ctrl_if.master  bus,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state;
    state_t state_d;

    logic        legal;
    logic        aligned;
    logic        accept;
    logic        reject;
    logic        data_req;
    logic        busy;
    logic        done;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [2:0]  width_q;
    logic [4:0]  rd_q;
    logic        misaligned_q;

    logic [31:0] shifted;
    logic [31:0] load_data;

    // Width legality and natural alignment of the incoming op.
    always_comb begin
        legal   = 1'b0;
        aligned = 1'b0;
        unique case (ex_lsu_width_type)
            3'b000: begin
                legal   = 1'b1;
                aligned = 1'b1;
            end
            3'b001: begin
                legal   = 1'b1;
                aligned = ~ex_lsu_addr[0];
            end
            3'b010: begin
                legal   = 1'b1;
                aligned = (ex_lsu_addr[1:0] == 2'b00);
            end
            3'b100: begin
                legal   = ~ex_lsu_wr_type;
                aligned = 1'b1;
            end
            3'b101: begin
                legal   = ~ex_lsu_wr_type;
                aligned = ~ex_lsu_addr[0];
            end
            default: begin
                legal   = 1'b0;
                aligned = 1'b0;
            end
        endcase
    end

    assign accept = (state == IDLE) & ex_lsu_valid & legal & aligned;
    assign reject = (state == IDLE) & ex_lsu_valid & ~(legal & aligned);

    // Byte enables and lane-replicated store data; width[1:0] selects size.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = ex_lsu_wdata;
        unique case (ex_lsu_width_type[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ex_lsu_addr[1:0];
                wdata_d = {4{ex_lsu_wdata[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {ex_lsu_addr[1], 1'b0};
                wdata_d = {2{ex_lsu_wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = ex_lsu_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        data_req = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                data_req = 1'b1;
                if (bus.data_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.data_rvalid) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Align the addressed lane down to bit 0, then extend by width.
    assign shifted = bus.data_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data = shifted;
        unique case (width_q)
            3'b000: load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001: load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100: load_data = {24'd0, shifted[7:0]};
            3'b101: load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            width_q      <= '0;
            rd_q         <= '0;
            misaligned_q <= 1'b0;
            wb_valid     <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
        end else begin
            misaligned_q <= reject;
            if (accept) begin
                addr_q  <= ex_lsu_addr;
                be_q    <= be_d;
                we_q    <= ex_lsu_wr_type;
                wdata_q <= wdata_d;
                width_q <= ex_lsu_width_type;
                rd_q    <= ex_dest_addr;
            end
            // x0 loads complete on the bus but never write back.
            wb_valid <= done & ~we_q & (rd_q != 5'd0);
            if (done & ~we_q) begin
                wb_addr <= rd_q;
                wb_data <= load_data;
            end
        end
    end

    assign lsu_busy       = busy;
    assign lsu_misaligned = misaligned_q;
    assign bus.data_req   = data_req;
    assign bus.data_we    = we_q;
    assign bus.data_be    = be_q;
    assign bus.data_addr  = {addr_q[31:2], 2'b00};
    assign bus.data_wdata = wdata_q;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameters: none; all widths fixed (RV32, 32-bit data bus, single outstanding access).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-003 ex_lsu_valid  in  1  memory op present from decode.
REQ-004 ex_lsu_wr_type  in  1  1=store, 0=load.
REQ-005 ex_lsu_width_type  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 ex_lsu_addr  in  32  effective address (ALU sum).
REQ-007 ex_lsu_wdata  in  32  store data (rs2).
REQ-008 ex_dest_addr  in  5  load destination register.
REQ-009 lsu_busy  out  1  stall request to decode; inputs held stable while high.
REQ-010 lsu_misaligned  out  1  one-cycle pulse on misaligned or illegal width.
REQ-011 data_req / data_gnt  out / in  1 / 1  request, grant.
REQ-012 data_we  out  1; data_be  out  4; data_addr  out  32, bits [1:0] forced 0; data_wdata  out  32.
REQ-013 data_rvalid  in  1; data_rdata  in  32  response.
REQ-014 wb_valid  out  1; wb_addr  out  5; wb_data  out  32  register-file write port.

Function
REQ-015 States SHALL be IDLE, REQ, WAIT; lsu_busy = (state != IDLE).
REQ-016 IDLE & ex_lsu_valid & legal & aligned: capture addr/be/we/wdata/width/rd, go to REQ next cycle.
REQ-017 Alignment: H/HU needs addr[0]=0; W needs addr[1:0]=00; B/BU always aligned.
REQ-018 Legal widths: loads 000/001/010/100/101; stores 000/001/010. Any other code is illegal.
REQ-019 Misaligned or illegal in IDLE: lsu_misaligned high the next cycle for exactly one cycle; no data_req; remain IDLE.
REQ-020 REQ: data_req=1; addr/be/we/wdata held constant until data_gnt; on data_gnt go to WAIT, data_req low the next cycle.
REQ-021 WAIT: data_req=0; on data_rvalid return to IDLE.
REQ-022 Store completion SHALL raise no wb_valid.
REQ-023 Load completion: wb_valid high the cycle after data_rvalid for one cycle, with wb_addr=captured rd; wb_valid suppressed if rd=0.
REQ-024 data_rvalid in IDLE or REQ SHALL be ignored.
REQ-025 data_be: B = 0001<<addr[1:0]; H = 0011<<{addr[1],0}; W = 1111.
REQ-026 data_wdata: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
REQ-027 Load data: shift rdata right by 8*addr[1:0]. B/H SHALL sign-extend bit 7/15; BU/HU zero-extend; W passes through.
REQ-028 Latency: ex_lsu_valid at cycle N; data_req at N+1 (grant same cycle); rvalid at N+2; wb_valid at N+3; lsu_busy high cycles N+1..N+2.
REQ-029 A new request is accepted only in IDLE; ex_lsu_valid while busy is not a new op.

Reset
REQ-030 reset SHALL take effect at the clock edge even mid-transaction: state=IDLE.
REQ-031 After reset, the following outputs SHALL be 0: data_req, data_we, data_be, data_addr, data_wdata, wb_valid, wb_addr, wb_data, lsu_misaligned, lsu_busy.
REQ-032 After a mid-transaction reset, a data_rvalid for the abandoned access SHALL be ignored.

Verification
REQ-033 LW at 0x100, gnt immediate, rdata=0xDEADBEEF, rd=5: data_be=1111, data_addr=0x100; then wb_valid=1, wb_addr=5, wb_data=0xDEADBEEF, 3 cycles after ex_lsu_valid.
REQ-034 LB at 0x103 with rdata=0x80FFFFFF gives wb_data=0xFFFFFF80; LBU at the same address gives 0x00000080; LHU at 0x102 with rdata=0x8001xxxx gives 0x00008001.
REQ-035 SH at 0x202 with wdata=0x1234ABCD: data_be=1100, data_wdata=0xABCDABCD, data_we=1, no wb_valid.
REQ-036 LW at 0x101 and SW with width 100: lsu_misaligned pulses one cycle; no data_req; lsu_busy stays 0.
REQ-037 Grant withheld 4 cycles: data_req and payload stable all 4 cycles; lsu_busy high throughout; a stray rvalid during REQ is ignored.
REQ-038 Reset in WAIT, then rvalid the next cycle: no wb_valid; next LW proceeds normally.
